linebuffer_ctrl: RTL and testbench

Sequencer for a bank of `NLINES` single-port-style line buffers feeding a K×K convolution window, where K = `NLINES`+1. It accepts a raster pixel stream and generates per-bank `wen`/`waddr`/`ren`/`raddr`, rotating the write bank at each line end. It aligns the incoming pixel with the buffered rows and flags when a full vertical window column is valid. It sits between the pixel source and the window/MAC stage of the CNN datapath.

---
 rtl/lbctrl_pkg.sv | 32 +++
 rtl/lbctrl_modcnt.sv | 40 ++++
 rtl/linebuffer_ctrl.sv | 153 +++++++++++++++
 tb/tb_linebuffer_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lbctrl_pkg.sv
// Shared types and width helpers for the line-buffer sequencer (linebuffer_ctrl).
package lbctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Index widths never collapse to zero bits, even for a single row or bank.
    function automatic int rowWidth(input int nrows);
        return (clog2(nrows) < 1) ? 1 : clog2(nrows);
    endfunction

    function automatic int bankWidth(input int nlines);
        return (clog2(nlines) < 1) ? 1 : clog2(nlines);
    endfunction

endpackage

// File: rtl/lbctrl_modcnt.sv
// Wrap counter with enable and clear; exposes the effective (post-clear) value of this cycle.
module lbctrl_modcnt
    import lbctrl_pkg::*;
#(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cur_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    // Clear and count in the same cycle count from zero, so the cleared pixel is consumed.
    always_comb begin
        base   = clr_i ? '0 : cnt_q;
        wrap_o = (base == W'(MOD - 1));
        cnt_d  = base;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : base + W'(1);
        end
    end

    assign cur_o = base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/linebuffer_ctrl.sv
// Line-buffer sequencer for a K x K window; optional column guard via LBCTRL_COLGUARD_EN.
module linebuffer_ctrl
    import lbctrl_pkg::*;
#(
    parameter int  LINEWIDTH   = 32,
    parameter int  LNLINEWIDTH = 5,
    parameter int  NLINES      = 2,
    parameter int  NROWS       = 32,
    localparam int ROW_W       = rowWidth(NROWS),
    localparam int BANK_W      = bankWidth(NLINES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sof_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [NLINES-1:0]      lb_wen_o,
    output logic                   lb_ren_o,
    output logic [LNLINEWIDTH-1:0] lb_waddr_o,
    output logic [LNLINEWIDTH-1:0] lb_raddr_o,
    output logic                   pix_en_o,
    output logic [BANK_W-1:0]      tap_base_o,
    output logic                   win_valid_o,
    output logic [ROW_W-1:0]       row_idx_o,
    output logic [LNLINEWIDTH-1:0] col_idx_o,
    output logic                   frame_done_o
);

    state_e state_q;
    state_e state_d;

    logic                   accept;
    logic                   proc;
    logic                   clr;
    logic                   colWrap;
    logic                   rowWrap;
    logic                   bankWrap;
    logic                   lastPix;
    logic                   rowNextFull;
    logic                   winNow;
    logic [LNLINEWIDTH-1:0] colCur;
    logic [ROW_W-1:0]       rowCur;
    logic [BANK_W-1:0]      bankCur;
    logic [ROW_W:0]         rowNext;

    logic                   winValid_q;
    logic [BANK_W-1:0]      tapBase_q;
    logic [ROW_W-1:0]       rowIdx_q;
    logic [LNLINEWIDTH-1:0] colIdx_q;

    assign in_ready_o = (state_q != DONE);
    assign accept     = in_valid_i & in_ready_o;
    // Outside a frame only a start-of-frame pixel is taken into the buffers.
    assign proc       = accept & ((state_q != IDLE) | sof_i);
    assign clr        = accept & sof_i;

    lbctrl_modcnt #(.MOD(LINEWIDTH), .W(LNLINEWIDTH)) colCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (proc),
        .clr_i (clr),
        .cur_o (colCur),
        .wrap_o(colWrap)
    );

    lbctrl_modcnt #(.MOD(NROWS), .W(ROW_W)) rowCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (proc & colWrap),
        .clr_i (clr),
        .cur_o (rowCur),
        .wrap_o(rowWrap)
    );

    lbctrl_modcnt #(.MOD(NLINES), .W(BANK_W)) bankCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (proc & colWrap),
        .clr_i (clr),
        .cur_o (bankCur),
        .wrap_o(bankWrap)
    );

    assign lastPix     = rowWrap & colWrap;
    assign rowNext     = {1'b0, rowCur} + {{ROW_W{1'b0}}, colWrap};
    assign rowNextFull = (int'(rowNext) >= NLINES);

`ifdef LBCTRL_COLGUARD_EN
    assign winNow = (int'(rowCur) >= NLINES) && (int'(colCur) >= NLINES);
`else
    assign winNow = (int'(rowCur) >= NLINES);
`endif

    // The oldest row lives in the bank being overwritten, so every bank is read at the write column.
    assign lb_wen_o     = proc ? (NLINES'(1) << bankCur) : '0;
    assign lb_ren_o     = proc;
    assign lb_waddr_o   = colCur;
    assign lb_raddr_o   = colCur;
    assign pix_en_o     = accept;
    assign frame_done_o = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DONE: state_d = IDLE;
            default: begin
                if (proc) begin
                    if (lastPix) begin
                        state_d = DONE;
                    end else if (rowNextFull) begin
                        state_d = RUN;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Window side-band is registered so it lines up with the buffer read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winValid_q <= 1'b0;
            tapBase_q  <= '0;
            rowIdx_q   <= '0;
            colIdx_q   <= '0;
        end else begin
            winValid_q <= proc & winNow;
            if (proc) begin
                tapBase_q <= bankCur;
                rowIdx_q  <= rowCur;
                colIdx_q  <= colCur;
            end
        end
    end

    assign win_valid_o = winValid_q;
    assign tap_base_o  = tapBase_q;
    assign row_idx_o   = rowIdx_q;
    assign col_idx_o   = colIdx_q;

    logic unusedBankWrap;
    assign unusedBankWrap = bankWrap;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Randomized self-checking bench for linebuffer_ctrl against a frame-position reference model.
module tb_linebuffer_ctrl;

    localparam int LW   = 4;
    localparam int LNW  = 2;
    localparam int NL   = 2;
    localparam int NR   = 4;
    localparam int NPIX = LW * NR;
`ifdef LBCTRL_COLGUARD_EN
    localparam int FRAME_PULSES = 4;
`else
    localparam int FRAME_PULSES = 8;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sof_i = 1'b0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [NL-1:0]  lb_wen_o;
    logic           lb_ren_o;
    logic [LNW-1:0] lb_waddr_o;
    logic [LNW-1:0] lb_raddr_o;
    logic           pix_en_o;
    logic [0:0]     tap_base_o;
    logic [1:0]     row_idx_o;
    logic [LNW-1:0] col_idx_o;
    logic           win_valid_o;
    logic           frame_done_o;

    linebuffer_ctrl #(
        .LINEWIDTH  (LW),
        .LNLINEWIDTH(LNW),
        .NLINES     (NL),
        .NROWS      (NR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sof_i       (sof_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .lb_wen_o    (lb_wen_o),
        .lb_ren_o    (lb_ren_o),
        .lb_waddr_o  (lb_waddr_o),
        .lb_raddr_o  (lb_raddr_o),
        .pix_en_o    (pix_en_o),
        .tap_base_o  (tap_base_o),
        .win_valid_o (win_valid_o),
        .row_idx_o   (row_idx_o),
        .col_idx_o   (col_idx_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulseCount = 0;

    // Reference model: position of the next pixel within the frame.
    bit mActive = 0;
    bit mDone = 0;
    int mPos = 0;
    bit mWin = 0;
    int mTap = 0;
    int mRow = 0;
    int mCol = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        mActive = 0;
        mDone = 0;
        mPos = 0;
        mWin = 0;
        mTap = 0;
        mRow = 0;
        mCol = 0;
    endtask

    task automatic checkResetState(input string phase);
        checkOutput({phase, "_in_ready"}, in_ready_o, 1);
        checkOutput({phase, "_lb_wen"}, lb_wen_o, 0);
        checkOutput({phase, "_lb_ren"}, lb_ren_o, 0);
        checkOutput({phase, "_lb_waddr"}, lb_waddr_o, 0);
        checkOutput({phase, "_lb_raddr"}, lb_raddr_o, 0);
        checkOutput({phase, "_pix_en"}, pix_en_o, 0);
        checkOutput({phase, "_tap_base"}, tap_base_o, 0);
        checkOutput({phase, "_win_valid"}, win_valid_o, 0);
        checkOutput({phase, "_row_idx"}, row_idx_o, 0);
        checkOutput({phase, "_col_idx"}, col_idx_o, 0);
        checkOutput({phase, "_frame_done"}, frame_done_o, 0);
    endtask

    // One clock cycle: drive, check against the model, then advance the model past the edge.
    task automatic applyStimulus(input bit sof, input bit valid);
        bit ready;
        bit accept;
        bit proc;
        int pp;
        int row;
        int col;
        int bank;
        @(negedge clk);
        sof_i = sof;
        in_valid_i = valid;
        #1;
        ready  = !mDone;
        accept = valid && ready;
        proc   = accept && (sof || mActive);
        pp     = sof ? 0 : mPos;
        row    = pp / LW;
        col    = pp % LW;
        bank   = row % NL;
        checkOutput("in_ready", in_ready_o, ready);
        checkOutput("frame_done", frame_done_o, mDone);
        checkOutput("pix_en", pix_en_o, accept);
        checkOutput("lb_ren", lb_ren_o, proc);
        checkOutput("lb_wen", lb_wen_o, proc ? (1 << bank) : 0);
        if (proc) begin
            checkOutput("lb_waddr", lb_waddr_o, col);
            checkOutput("lb_raddr", lb_raddr_o, col);
        end
        checkOutput("win_valid", win_valid_o, mWin);
        checkOutput("tap_base", tap_base_o, mTap);
        checkOutput("row_idx", row_idx_o, mRow);
        checkOutput("col_idx", col_idx_o, mCol);
        if (win_valid_o === 1'b1) pulseCount++;

        mDone = 0;
        if (proc) begin
`ifdef LBCTRL_COLGUARD_EN
            mWin = (row >= NL) && (col >= NL);
`else
            mWin = (row >= NL);
`endif
            mTap = bank;
            mRow = row;
            mCol = col;
            if (pp == NPIX - 1) begin
                mDone = 1;
                mActive = 0;
                mPos = 0;
            end else begin
                mActive = 1;
                mPos = pp + 1;
            end
        end else begin
            mWin = 0;
        end
    endtask

    initial begin
        #3;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full back-to-back frame.
        pulseCount = 0;
        applyStimulus(1, 1);
        for (int i = 1; i < NPIX; i++) applyStimulus(0, 1);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("frame_pulses", pulseCount, FRAME_PULSES);

        // Frame with a three-cycle input gap inside row 1.
        pulseCount = 0;
        applyStimulus(1, 1);
        for (int i = 1; i < 6; i++) applyStimulus(0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0);
        for (int i = 6; i < NPIX; i++) applyStimulus(0, 1);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("gap_pulses", pulseCount, FRAME_PULSES);

        // Abort with sof at row 1, col 2, then finish the restarted frame.
        applyStimulus(1, 1);
        for (int i = 1; i < 6; i++) applyStimulus(0, 1);
        pulseCount = 0;
        applyStimulus(1, 1);
        for (int i = 1; i < 8; i++) applyStimulus(0, 1);
        applyStimulus(0, 1);
        checkOutput("abort_pulses", pulseCount, 0);
        for (int i = 9; i < NPIX; i++) applyStimulus(0, 1);
        applyStimulus(0, 0);
        applyStimulus(0, 0);

        // Random valid gaps and occasional sof, including dropped idle pixels.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 32) == 0, ($urandom % 4) != 0);
        end

        // Reset asserted in the middle of RUN.
        applyStimulus(1, 1);
        for (int i = 1; i < 10; i++) applyStimulus(0, 1);
        sof_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1);
        applyStimulus(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
